// File: rtl/ex_mdu.sv
// Multiply/divide unit for the EX stage: fixed-latency mult/div that holds the
// result privately and commits it to HI/LO only when the countdown expires.
module ex_mdu #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);
    localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        res_hi_q, res_hi_d;
    logic [31:0]        res_lo_q, res_lo_d;
    logic               commit_q, commit_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic               is_mul, is_div;
    logic [63:0]        mul_res, div_res;

    function automatic logic [63:0] mul_full(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic signed [63:0] xe, ye, p;
        xe = $signed({{32{sgn & x[31]}}, x});
        ye = $signed({{32{sgn & y[31]}}, y});
        p  = xe * ye;
        return p;
    endfunction

    // Magnitude divide then re-sign; this also yields 0x80000000 / -1 = 0x80000000, rem 0.
    function automatic logic [63:0] div_full(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        logic        nx, ny;
        logic [31:0] ux, uy, q, r;
        nx = sgn & x[31];
        ny = sgn & y[31];
        ux = nx ? 32'd0 - x : x;
        uy = ny ? 32'd0 - y : y;
        if (uy == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = ux / uy;
            r = ux % uy;
        end
        if (nx ^ ny) q = 32'd0 - q;
        if (nx)      r = 32'd0 - r;
        return {r, q};
    endfunction

    assign is_mul  = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
    assign is_div  = (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
    assign mul_res = mul_full(a, b, mdu_op == OP_MULT);
    assign div_res = div_full(a, b, mdu_op == OP_DIV);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            commit_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            commit_q <= commit_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        commit_d = commit_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start && (is_mul || is_div)) begin
                    state_d  = S_RUN;
                    cnt_d    = is_mul ? CNT_W'(MULT_CYC) : CNT_W'(DIV_CYC);
                    res_hi_d = is_mul ? mul_res[63:32] : div_res[63:32];
                    res_lo_d = is_mul ? mul_res[31:0]  : div_res[31:0];
                    // A zero divisor still occupies the unit but never commits.
                    commit_d = is_mul || (b != 32'd0);
                end
                if (mdu_op == OP_MTHI) hi_d = a;
                if (mdu_op == OP_MTLO) lo_d = a;
            end
            S_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    if (commit_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (mdu_op)
            OP_MFHI: mdu_out = hi_q;
            OP_MFLO: mdu_out = lo_q;
            default: mdu_out = 32'd0;
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu: a cycle-level reference model queues expected
// completions on accept; a negedge monitor checks busy, HI/LO and mdu_out.
module tb_ex_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  mdu_op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy;
    logic [31:0] hi, lo, mdu_out;

    ex_mdu #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
        .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo), .mdu_out(mdu_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
    } exp_t;

    exp_t        sbq[$];
    int          vectors = 0;
    int          errs = 0;
    int          checks = 0;

    // Reference model: architectural HI/LO plus remaining busy cycles.
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
    logic [31:0] p_hi = 32'd0, p_lo = 32'd0;
    int          m_rem = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0;
            m_hi  = 32'd0;
            m_lo  = 32'd0;
            sbq.delete();
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end else if (start && mdu_op >= 4'd1 && mdu_op <= 4'd4) begin
            logic signed [63:0] sp, sq, sr;
            logic [63:0]        up;
            exp_t               e;
            p_hi = m_hi;
            p_lo = m_lo;
            case (mdu_op)
                4'd1: begin
                    sp = longint'($signed(a)) * longint'($signed(b));
                    p_hi = sp[63:32]; p_lo = sp[31:0];
                end
                4'd2: begin
                    up = {32'd0, a} * {32'd0, b};
                    p_hi = up[63:32]; p_lo = up[31:0];
                end
                4'd3: if (b != 0) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    p_hi = sr[31:0]; p_lo = sq[31:0];
                end
                default: if (b != 0) begin
                    p_hi = a % b; p_lo = a / b;
                end
            endcase
            m_rem = (mdu_op <= 4'd2) ? 5 : 10;
            e.hi = p_hi; e.lo = p_lo; e.n = m_rem;
            sbq.push_back(e);
        end else begin
            if (mdu_op == 4'd7) m_hi = a;
            if (mdu_op == 4'd8) m_lo = a;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    int   busy_len = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        logic [31:0] exp_out;
        exp_out = (mdu_op == 4'd5) ? m_hi : (mdu_op == 4'd6) ? m_lo : 32'd0;
        chk("busy", {31'd0, busy}, {31'd0, m_rem > 0});
        chk("hi", hi, m_hi);
        chk("lo", lo, m_lo);
        chk("mdu_out", mdu_out, exp_out);
        if (reset) begin
            busy_len  = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy) busy_len++;
            if (prev_busy && !busy) begin
                if (sbq.size() == 0) begin
                    chk("sb_empty_on_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("done_len", busy_len, e.n);
                    chk("done_hi", hi, e.hi);
                    chk("done_lo", lo, e.lo);
                end
                busy_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic drive(input logic s, input logic [3:0] op,
                         input logic [31:0] aa, input logic [31:0] bb);
        start  = s;
        mdu_op = op;
        a      = aa;
        b      = bb;
        vectors++;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            4: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        drive(1, 4'd1, 32'hFFFFFFFE, 32'd3);      // mult at first edge out of reset
        idle(6);
        drive(1, 4'd2, 32'hFFFFFFFE, 32'd3);      // multu
        idle(6);
        drive(1, 4'd3, 32'hFFFFFFF9, 32'd2);      // div -7/2
        idle(11);
        drive(1, 4'd4, 32'd7, 32'd0);             // divu by zero
        idle(11);
        drive(0, 4'd7, 32'h12345678, 32'd0);      // mthi then mfhi
        drive(0, 4'd5, 32'd0, 32'd0);
        drive(0, 4'd8, 32'hCAFEF00D, 32'd0);      // mtlo then mflo
        drive(0, 4'd6, 32'd0, 32'd0);
        drive(1, 4'd2, 32'h00010000, 32'h00010000);
        drive(0, 4'd8, 32'hDEADBEEF, 32'd0);      // mtlo while busy
        idle(5);
        drive(1, 4'd1, 32'd100, 32'hFFFFFFFF);    // mult, then ignored div
        idle(1);
        drive(1, 4'd3, 32'd50, 32'd7);
        idle(5);
        drive(1, 4'd2, 32'd9, 32'd9);             // completion coincides with mthi
        idle(4);
        drive(0, 4'd7, 32'h55555555, 32'd0);
        drive(0, 4'd5, 32'd0, 32'd0);
        drive(1, 4'd1, 32'd3, 32'd4);             // back-to-back starts
        idle(4);
        drive(1, 4'd1, 32'd5, 32'd6);
        drive(1, 4'd1, 32'd7, 32'd8);
        idle(6);
        drive(1, 4'd3, 32'h80000000, 32'hFFFFFFFF);
        idle(11);
        drive(1, 4'd3, 32'd1000, 32'd3);          // reset 3 cycles into div
        idle(2);
        reset = 1'b1;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        idle(10);
        for (int i = 0; i < 300; i++)
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rnd_val(), rnd_val());
        idle(15);
        chk("sb_drained", sbq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 The module SHALL have a single clock and an asynchronous active-high reset: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-002 start  input  1  MDU operation request, EX stage; meaningful only for mult/multu/div/divu.
REQ-003 mdu_op  input  4  operation code:
- 0 none
- 1 mult
- 2 multu
- 3 div
- 4 divu
- 5 mfhi
- 6 mflo
- 7 mthi
- 8 mtlo
- 9-15 treated as none
REQ-004 a  input  32  forwarded rs operand (E stage).
REQ-005 b  input  32  forwarded rt operand (E stage).
REQ-006 busy  output  1  a mult/div is in flight.
REQ-007 hi  output  32  architectural HI register.
REQ-008 lo  output  32  architectural LO register.
REQ-009 mdu_out  output  32  mfhi/mflo read data for the EX result mux.

Function
REQ-010 Parameters: MULT_CYC, default 5, multiply latency; DIV_CYC, default 10, divide latency.
REQ-011 Internal state: idle/run flag, cycle counter, pending-result registers res_hi/res_lo.
REQ-012 Accept: when start=1, mdu_op in 1..4 and busy=0 at a rising edge, the block SHALL latch the computed result into res_hi/res_lo, load the counter with MULT_CYC (ops 1,2) or DIV_CYC (ops 3,4), and set busy=1 after that edge.
REQ-013 Countdown: while busy=1 the counter SHALL decrement by 1 per edge. The edge at which the counter goes 1->0 SHALL copy res_hi->hi and res_lo->lo and clear busy in the same edge. busy is therefore high for exactly MULT_CYC or DIV_CYC cycles after the accept edge.
REQ-014 HI/LO SHALL not change during the countdown; intermediate results are never visible.
REQ-015 start while busy=1 SHALL be ignored; no restart or counter reload. The hazard unit stalls such instructions.
REQ-016 start with mdu_op outside 1..4 SHALL be ignored.
REQ-017 mult: {hi,lo} = signed(a)*signed(b), full 64 bits. multu: same, unsigned.
REQ-018 div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend a.
REQ-019 div special case: a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0.
REQ-020 divu: lo = a/b, hi = a%b, both unsigned.
REQ-021 Divide by zero (b=0, div or divu): the op SHALL be accepted and busy SHALL run the full DIV_CYC, but hi/lo SHALL be left unchanged at completion.
REQ-022 mthi (7) / mtlo (8): at a rising edge with busy=0, hi<=a or lo<=a respectively. When busy=1 the write SHALL be suppressed.
REQ-023 mdu_out SHALL be combinational: hi when mdu_op=5, lo when mdu_op=6, 0 otherwise. It reflects the committed registers only.
REQ-024 Completion edge coinciding with mthi/mtlo: the completion write SHALL take effect and the mthi/mtlo write is dropped, because busy=1 at that edge.
REQ-025 Back-to-back: a new start at the edge busy clears is ignored (busy=1 at that edge). A start one cycle later SHALL be accepted.

Reset
REQ-026 reset=1 SHALL asynchronously force busy=0, counter=0, hi=0, lo=0, res_hi=0, res_lo=0. mdu_out then reads 0.
REQ-027 Reset mid-operation SHALL abort the pending op; no HI/LO commit after reset deasserts.
REQ-028 The first accept is possible at the first rising edge with reset=0.

Verification
REQ-029 mult a=0xFFFFFFFE, b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with same operands -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-030 div a=0xFFFFFFF9 (-7), b=2 -> busy high 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> busy 10 cycles; hi/lo unchanged.
REQ-031 mthi a=0x12345678, then mdu_op=5 next cycle -> mdu_out=0x12345678. mtlo issued while busy=1 -> lo unchanged.
REQ-032 mult started, second start with div two cycles later -> ignored; busy drops exactly 5 cycles after the first accept; result is the mult.
REQ-033 Assert reset 3 cycles into a div -> busy=0, hi=lo=0 immediately; values still 0 ten cycles later.
REQ-034 div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0x00000000 after 10 cycles.
